// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// reset PC, RAM read latency and the prefetch queue entry layout.
package fetch_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 4;
  localparam int RESET_PC_DEF   = 0;

  // Cycles from issuing a read to the word appearing on mem_dout.
  localparam int RD_LATENCY     = 1;

  // One prefetch queue slot: the fetched word and the address it came from.
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic [ADDR_WIDTH_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: DEPTH-entry circular buffer with wrapping pointers.
// The head entry is read straight out of registered storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        din,
  output entry_t        dout,
  output logic [CW-1:0] count
);

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   wptr_r;
  logic [PW-1:0]   rptr_r;
  logic [CW-1:0]   count_r;
  logic            do_pop_s;

  // A pop against an empty queue is a no-op.
  assign do_pop_s = pop & (count_r != CW'(0));
  assign dout     = mem_r[rptr_r];
  assign count    = count_r;

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
      case ({push, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_r[wptr_r] <= din;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads to a synchronous
// RAM under a credit rule that reserves a queue slot for every outstanding
// read, and squashes queued and in-flight words on a redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    DEPTH      = DEPTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_rw,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  stall
);

  localparam int CW = $clog2(DEPTH + 1);
  // Wide enough for queue occupancy plus every read still in the RAM pipe.
  localparam int SW = $clog2(DEPTH + RD_LATENCY + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0]                    pc_r;
  logic [RD_LATENCY-1:0]                    inflight_r;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0]    inflight_pc_r;
  logic [CW-1:0]                            count_s;
  logic [SW-1:0]                            occ_s;
  logic                                     pop_s;
  logic                                     push_s;
  logic                                     issue_s;
  entry_t                                   push_entry_s;
  entry_t                                   head_s;

  assign mem_a        = pc_r;
  assign mem_rw       = 1'b0;
  assign mem_en       = issue_s;
  assign instr_valid  = (count_s != CW'(0));
  assign instr_data   = head_s.data;
  assign instr_pc     = head_s.pc;
  assign pop_s        = instr_valid & instr_ready;
  // A word landing in the same cycle as a redirect belongs to the old path.
  assign push_s       = inflight_r[RD_LATENCY-1] & ~redirect_valid;
  assign push_entry_s = '{data: mem_dout, pc: inflight_pc_r[RD_LATENCY-1]};

  // Issue a read only when a queue slot is guaranteed once it returns.
  always_comb begin
    occ_s = SW'(count_s) + SW'($countones(inflight_r)) - SW'(pop_s);
    if (!rst && !stall && !redirect_valid && (occ_s < SW'(DEPTH))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Program counter: redirect wins, otherwise advance on every issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= redirect_pc;
    end else if (issue_s) begin
      pc_r <= pc_r + ADDR_WIDTH'(1);
    end
  end

  // Track reads travelling through the RAM; a redirect kills all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r    <= '0;
      inflight_pc_r <= '0;
    end else if (redirect_valid) begin
      inflight_r    <= '0;
    end else begin
      inflight_r[0]    <= issue_s;
      inflight_pc_r[0] <= pc_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        inflight_r[i]    <= inflight_r[i-1];
        inflight_pc_r[i] <= inflight_pc_r[i-1];
      end
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .din   (push_entry_s),
    .dout  (head_s),
    .count (count_s)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SAW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (default widths)
  logic          rst = 1'b1;
  logic [AW-1:0] mem_a;
  logic          mem_rw, mem_en;
  logic [DW-1:0] mem_dout = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          stall = 1'b0;

  // narrow instance for PC wrap and non-zero reset PC
  logic           w_rst = 1'b1;
  logic [SAW-1:0] w_mem_a;
  logic           w_mem_rw, w_mem_en;
  logic [DW-1:0]  w_mem_dout = '0;
  logic           w_instr_valid;
  logic           w_instr_ready = 1'b1;
  logic [DW-1:0]  w_instr_data;
  logic [SAW-1:0] w_instr_pc;
  logic           w_redirect_valid = 1'b0;
  logic [SAW-1:0] w_redirect_pc = '0;
  logic           w_stall = 1'b0;

  instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_rw(mem_rw), .mem_en(mem_en),
    .mem_dout(mem_dout), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall));

  instr_fetch_unit #(.ADDR_WIDTH(SAW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(4'd14)) dut_w (
    .clk(clk), .rst(w_rst), .mem_a(w_mem_a), .mem_rw(w_mem_rw), .mem_en(w_mem_en),
    .mem_dout(w_mem_dout), .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
    .instr_data(w_instr_data), .instr_pc(w_instr_pc), .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc), .stall(w_stall));

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h0000_1000 + a;
  endfunction

  // RAM models: 1-cycle read latency; garbage on cycles without a read
  always @(posedge clk) begin
    if (mem_en) mem_dout <= word_of(mem_a);
    else        mem_dout <= $urandom;
  end
  always @(posedge clk) begin
    if (w_mem_en) w_mem_dout <= 32'h0000_2000 + {28'd0, w_mem_a};
    else          w_mem_dout <= $urandom;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected queue contents as a list of fetch addresses,
  // the address whose read is in the RAM, and the next fetch address.
  logic [31:0] mq[$];
  logic [31:0] mpc = 32'd0;
  bit          minf = 1'b0;
  logic [31:0] minf_pc = 32'd0;

  task automatic step(input bit rdy, input bit stl, input bit rv, input logic [31:0] rpc);
    bit pop, issue;
    int occ;
    @(negedge clk);
    instr_ready = rdy; stall = stl; redirect_valid = rv; redirect_pc = rpc;
    #1;
    pop   = (mq.size() != 0) && rdy;
    occ   = mq.size() + int'(minf) - int'(pop);
    issue = !stl && !rv && (occ < DEPTH);
    check_val("instr_valid", instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_val("instr_pc", instr_pc, mq[0]);
      check_val("instr_data", instr_data, word_of(mq[0]));
    end
    check_val("mem_en", mem_en, issue);
    check_val("mem_rw", mem_rw, 1'b0);
    if (issue) check_val("mem_a", mem_a, mpc);
    if (rv) begin
      mq.delete();
      minf = 1'b0;
      mpc  = rpc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (minf) mq.push_back(minf_pc);
      minf    = issue;
      minf_pc = mpc;
      if (issue) mpc = mpc + 32'd1;
    end
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic do_reset();
    stall = 1'b0; redirect_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_val("rst_valid", instr_valid, 1'b0);
    check_val("rst_mem_en", mem_en, 1'b0);
    check_val("rst_data", instr_data, 32'd0);
    check_val("rst_pc", instr_pc, 32'd0);
    check_val("rst_mem_a", mem_a, 32'd0);
    mq.delete(); minf = 1'b0; mpc = 32'd0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int got;
    logic [3:0] wexp [4];
    wexp[0] = 4'd14; wexp[1] = 4'd15; wexp[2] = 4'd0; wexp[3] = 4'd1;

    do_reset();
    w_rst = 1'b0;
    // streaming with decode always ready
    repeat (12) step(1'b1, 1'b0, 1'b0, 32'd0);
    // backpressure until full, then drain
    repeat (10) step(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (12) step(1'b1, 1'b0, 1'b0, 32'd0);
    // redirect with queue filling and a read in flight
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'd0);
    // redirect coinciding with a pop and a response
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h40);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'd0);
    // stall while streaming
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'd0);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'd0);
    // redirect together with stall, then near the top of the address space
    step(1'b1, 1'b1, 1'b1, 32'h80);
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'd0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'd0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
           $urandom_range(0, 19) == 0, rpc);
    end
    // async reset in the middle of a stream
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'd0);
    do_reset();
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'd0);

    // narrow instance: async reset mid-stream, then RESET_PC 14 wrapping to 0
    @(negedge clk);
    check_val("w_streaming", w_instr_valid, 1'b1);
    check_val("w_mem_rw", w_mem_rw, 1'b0);
    #3 w_rst = 1'b1;
    #1;
    check_val("w_rst_valid", w_instr_valid, 1'b0);
    check_val("w_rst_mem_a", w_mem_a, 4'd14);
    @(posedge clk);
    #1 w_rst = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (w_instr_valid) begin
        check_val("w_cycle", c, 2 + got);
        check_val("w_pc", w_instr_pc, wexp[got]);
        check_val("w_data", w_instr_data, 32'h0000_2000 + {28'd0, wexp[got]});
        got++;
      end
    end
    check_val("w_words_seen", got, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
